sfifo_wr_arb: RTL and testbench
===============================

Name: sfifo_wr_arb

Overview:
- Two-requester write arbiter and controller for one shared synchronous FIFO.
- Arbitrates requester 0 and requester 1 round-robin into a single 1R1W storage array. The storage is instantiated internally as the team's 1R1W RAM: asynchronous read, synchronous write.
- Tags each entry with its source ID and drains it through a valid/ready read port.
- Sits between two bus-side producers (e.g. two AXI write-data streams) and a single consumer.

Parameters:
- SFIFODW, 32, data width per entry (the source tag is stored as one extra internal bit).
- SFIFOAW, 2, pointer width.
- SFIFODP, 4, depth in entries; must equal 2**SFIFOAW.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 write request.
- wdata0  input  SFIFODW  requester 0 write data.
- gnt0  output  1  requester 0 grant; a write occurs in any cycle where req0 and gnt0 are both high.
- req1  input  1  requester 1 write request.
- wdata1  input  SFIFODW  requester 1 write data.
- gnt1  output  1  requester 1 grant.
- rvalid  output  1  head entry available.
- rready  input  1  consumer accepts head entry.
- rdata  output  SFIFODW  head entry data.
- rsrc  output  1  head entry source ID (0 or 1).
- level  output  SFIFOAW+1  current occupancy, 0..SFIFODP.
- full  output  1  level == SFIFODP.
- empty  output  1  level == 0.
- acc0_cnt  output  16  accepted-write count, requester 0 (see Optional Feature).
- acc1_cnt  output  16  accepted-write count, requester 1.

Behaviour:
- Reset: wadr=0, radr=0, level=0, rr_last=1 (requester 0 wins the first tie). Outputs after reset: empty=1, full=0, rvalid=0, gnt0=gnt1=0. RAM contents are don't-care.
- Reset mid-operation discards all entries immediately. No grant or pop is honoured while rst_n is low.
- Grant is combinational from req and registered state:
  - gnt0 = req0 & ~full & (~req1 | rr_last==1)
  - gnt1 = req1 & ~full & (~req0 | rr_last==0)
  - gnt0 and gnt1 are never high together.
- rr_last updates to the granted ID on each accepted write. It is unchanged when no write occurs.
- Requester protocol: hold req and wdata stable until a grant is seen. Dropping req without a grant is legal and has no side effects.
- Accepted write:
  - Write RAM[wadr] = {source ID, wdata of the winner}.
  - wadr increments by 1 and wraps from SFIFODP-1 to 0.
  - The write is visible on the read port in the next cycle (write-to-rvalid latency of 1 when the FIFO was empty).
- Read side:
  - rvalid = ~empty; rdata/rsrc = RAM[radr] (combinational).
  - A pop occurs when rvalid & rready. radr increments and wraps like wadr.
  - rready while empty is ignored.
- level update: +1 on write only, -1 on pop only, unchanged on write and pop in the same cycle.
- full is computed from the registered level only. A pop in the same cycle does not allow a write while full: no pass-through.
- Simultaneous write and pop when level==1: both occur, level stays 1, and the new entry becomes the head next cycle.
- No overflow or underflow is possible by construction. The bench asserts level never exceeds SFIFODP.

Optional Feature:
- Macro SFIFO_ARB_STAT_EN.
- Defined:
  - acc0_cnt and acc1_cnt are 16-bit registers, reset to 0.
  - Each increments by 1 on every accepted write from its requester.
  - Each saturates at 16'hFFFF with no wrap.
- Not defined: acc0_cnt and acc1_cnt are tied to 16'h0000 and no counter flops are built. All other behaviour is identical.

Test Plan (SFIFODW=32, SFIFOAW=2, SFIFODP=4):
- Reset, then req0=1 with wdata0=32'hA5A5_0001 for one cycle.
  - Required: gnt0=1 in the same cycle.
  - Next cycle: rvalid=1, rdata=32'hA5A5_0001, rsrc=0, level=1.
- req0 and req1 both held high from reset, rready=0.
  - Required: grants alternate 0,1,0,1.
  - Then full=1, level=4, gnt0=gnt1=0.
  - Popping with rready=1 returns rsrc sequence 0,1,0,1.
- With the FIFO full, rready=1 and req1=1 in the same cycle.
  - Required: pop occurs and gnt1=0 that cycle, level=3.
  - Next cycle: gnt1=1, level back to 4.
- Ten writes and ten pops interleaved with level held at 1 or 2.
  - Required: data is returned in order across pointer wrap (wadr/radr pass 3->0 twice), and empty=1 at the end.
- Write three entries, assert rst_n=0 for one cycle mid-stream.
  - Required: level=0, empty=1, rvalid=0 immediately.
  - The first write after reset goes to requester 0 on a tie.
- With SFIFO_ARB_STAT_EN: 5 writes from requester 0 and 3 from requester 1.
  - Required: acc0_cnt=5, acc1_cnt=3.
  - Without the macro, both read 0.

Source files
------------

// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb: round-robin two-requester write arbiter feeding one source-tagged 1R1W FIFO
// Optional saturating per-requester accepted-write counters are built when SFIFO_ARB_STAT_EN is defined.
module sfifo_wr_arb #(
  parameter int SFIFODW = 32,
  parameter int SFIFOAW = 2,
  parameter int SFIFODP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0,
  input  logic [SFIFODW-1:0] wdata0,
  output logic               gnt0,
  input  logic               req1,
  input  logic [SFIFODW-1:0] wdata1,
  output logic               gnt1,
  output logic               rvalid,
  input  logic               rready,
  output logic [SFIFODW-1:0] rdata,
  output logic               rsrc,
  output logic [SFIFOAW:0]   level,
  output logic               full,
  output logic               empty,
  output logic [15:0]        acc0_cnt,
  output logic [15:0]        acc1_cnt
);
  localparam logic [SFIFOAW:0] LVL_FULL = (SFIFOAW+1)'(SFIFODP);
  logic [SFIFOAW-1:0] wadr, radr;
  logic rr_last, wr, pop;
  logic [SFIFODW:0] mem [SFIFODP];
  logic [SFIFODW:0] head;
  assign full = level == LVL_FULL;
  assign empty = level == '0;
  assign gnt0 = rst_n & req0 & ~full & (~req1 | rr_last);
  assign gnt1 = rst_n & req1 & ~full & (~req0 | ~rr_last);
  assign wr = gnt0 | gnt1;
  assign rvalid = ~empty;
  assign pop = rvalid & rready;
  assign head = mem[radr];
  assign rdata = head[SFIFODW-1:0];
  assign rsrc = head[SFIFODW];
  // storage write of {source, data}; contents need no reset
  always_ff @(posedge clk)
    if (wr) mem[wadr] <= {gnt1, gnt1 ? wdata1 : wdata0};
  // pointers, occupancy and round-robin history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wadr <= '0;
      radr <= '0;
      level <= '0;
      rr_last <= 1'b1;
    end else begin
      if (wr) wadr <= wadr + 1'b1;
      if (wr) rr_last <= gnt1;
      if (pop) radr <= radr + 1'b1;
      if (wr != pop) level <= wr ? level + 1'b1 : level - 1'b1;
    end
`ifdef SFIFO_ARB_STAT_EN
  // saturating accepted-write counters per requester
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc0_cnt <= '0;
      acc1_cnt <= '0;
    end else begin
      if (gnt0 && acc0_cnt != 16'hFFFF) acc0_cnt <= acc0_cnt + 16'd1;
      if (gnt1 && acc1_cnt != 16'hFFFF) acc1_cnt <= acc1_cnt + 16'd1;
    end
`else
  assign acc0_cnt = '0;
  assign acc1_cnt = '0;
`endif
endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb: directed bench for the two-requester tagged FIFO arbiter
module tb_sfifo_wr_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, rready = 1'b0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid, rsrc, full, empty;
  logic [31:0] rdata;
  logic [2:0] level;
  logic [15:0] acc0_cnt, acc1_cnt;
  int ncmp = 0;
  int nerr = 0;
  sfifo_wr_arb #(.SFIFODW(32), .SFIFOAW(2), .SFIFODP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wdata0(wdata0), .gnt0(gnt0),
    .req1(req1), .wdata1(wdata1), .gnt1(gnt1),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rsrc(rsrc),
    .level(level), .full(full), .empty(empty),
    .acc0_cnt(acc0_cnt), .acc1_cnt(acc1_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // occupancy must never exceed the depth
  always @(negedge clk)
    if (rst_n) begin
      ncmp++;
      assert (level <= 3'd4) else begin
        nerr++;
        $error("FAIL level_bound: observed %0d expected <= 4", level);
      end
    end
  initial begin
    logic [31:0] d;
    // reset state
    @(negedge clk); #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_gnt1", 64'(gnt1), 64'd0);
    // single write from requester 0
    @(negedge clk); req0 = 1'b1; wdata0 = 32'hA5A5_0001; #1;
    chk("t1_gnt0", 64'(gnt0), 64'd1);
    chk("t1_gnt1", 64'(gnt1), 64'd0);
    @(negedge clk); req0 = 1'b0; #1;
    chk("t1_rvalid", 64'(rvalid), 64'd1);
    chk("t1_rdata", 64'(rdata), 64'hA5A5_0001);
    chk("t1_rsrc", 64'(rsrc), 64'd0);
    chk("t1_level", 64'(level), 64'd1);
    rready = 1'b1;
    @(negedge clk); rready = 1'b0; #1;
    chk("t1_empty", 64'(empty), 64'd1);
    // both requesters held from reset, no reads
    @(negedge clk); rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    wdata0 = 32'h0000_0100; wdata1 = 32'h0000_0200; #1;
    chk("t2_rst_gnt0", 64'(gnt0), 64'd0);
    chk("t2_rst_gnt1", 64'(gnt1), 64'd0);
    chk("t2_rst_level", 64'(level), 64'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("t2_g0_gnt0", 64'(gnt0), 64'd1);
    chk("t2_g0_gnt1", 64'(gnt1), 64'd0);
    @(negedge clk); #1;
    chk("t2_g1_gnt0", 64'(gnt0), 64'd0);
    chk("t2_g1_gnt1", 64'(gnt1), 64'd1);
    chk("t2_g1_level", 64'(level), 64'd1);
    @(negedge clk); #1;
    chk("t2_g2_gnt0", 64'(gnt0), 64'd1);
    chk("t2_g2_gnt1", 64'(gnt1), 64'd0);
    chk("t2_g2_level", 64'(level), 64'd2);
    @(negedge clk); #1;
    chk("t2_g3_gnt0", 64'(gnt0), 64'd0);
    chk("t2_g3_gnt1", 64'(gnt1), 64'd1);
    chk("t2_g3_level", 64'(level), 64'd3);
    @(negedge clk); #1;
    chk("t2_full", 64'(full), 64'd1);
    chk("t2_level4", 64'(level), 64'd4);
    chk("t2_full_gnt0", 64'(gnt0), 64'd0);
    chk("t2_full_gnt1", 64'(gnt1), 64'd0);
    // full: pop and request in the same cycle, no pass-through
    req0 = 1'b0; rready = 1'b1; #1;
    chk("t3_gnt1_blocked", 64'(gnt1), 64'd0);
    chk("t3_head_rsrc", 64'(rsrc), 64'd0);
    chk("t3_head_rdata", 64'(rdata), 64'h100);
    @(negedge clk); rready = 1'b0; #1;
    chk("t3_level3", 64'(level), 64'd3);
    chk("t3_gnt1", 64'(gnt1), 64'd1);
    chk("t3_head2_rsrc", 64'(rsrc), 64'd1);
    @(negedge clk); req1 = 1'b0; #1;
    chk("t3_level4", 64'(level), 64'd4);
    chk("t3_refull", 64'(full), 64'd1);
    // drain: remaining order 1,0,1 then the late requester-1 entry
    rready = 1'b1; #1;
    chk("t3_pop1_rsrc", 64'(rsrc), 64'd1);
    chk("t3_pop1_rdata", 64'(rdata), 64'h200);
    @(negedge clk); #1;
    chk("t3_pop2_rsrc", 64'(rsrc), 64'd0);
    chk("t3_pop2_rdata", 64'(rdata), 64'h100);
    @(negedge clk); #1;
    chk("t3_pop3_rsrc", 64'(rsrc), 64'd1);
    chk("t3_pop3_rdata", 64'(rdata), 64'h200);
    @(negedge clk); #1;
    chk("t3_pop4_rsrc", 64'(rsrc), 64'd1);
    chk("t3_pop4_rdata", 64'(rdata), 64'h200);
    @(negedge clk); #1;
    chk("t3_empty", 64'(empty), 64'd1);
    chk("t3_rvalid", 64'(rvalid), 64'd0);
    // ten writes and ten pops interleaved across two pointer wraps
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      d = 32'hC0DE_0000 + 32'(i);
      req0 = (i < 10) && (i % 2 == 0);
      req1 = (i < 10) && (i % 2 == 1);
      wdata0 = d; wdata1 = d; rready = (i > 0); #1;
      if (i < 10) chk($sformatf("t4_gnt_%0d", i), 64'(gnt0 | gnt1), 64'd1);
      if (i > 0) begin
        chk($sformatf("t4_rdata_%0d", i - 1), 64'(rdata), 64'(d - 32'd1));
        chk($sformatf("t4_rsrc_%0d", i - 1), 64'(rsrc), 64'((i - 1) % 2));
        chk($sformatf("t4_level_%0d", i), 64'(level), 64'd1);
      end
    end
    @(negedge clk); rready = 1'b0; #1;
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_level0", 64'(level), 64'd0);
    // three writes then reset mid-stream
    req0 = 1'b1; wdata0 = 32'h5555_0000;
    repeat (3) @(negedge clk);
    #1;
    chk("t5_level3", 64'(level), 64'd3);
    rst_n = 1'b0; req1 = 1'b1; #1;
    chk("t5_rst_level", 64'(level), 64'd0);
    chk("t5_rst_empty", 64'(empty), 64'd1);
    chk("t5_rst_rvalid", 64'(rvalid), 64'd0);
    chk("t5_rst_gnt", 64'({gnt1, gnt0}), 64'd0);
    @(negedge clk); rst_n = 1'b1; rready = 1'b1; #1;
    chk("t5_tie_gnt0", 64'(gnt0), 64'd1);
    chk("t5_tie_gnt1", 64'(gnt1), 64'd0);
    // 5 writes from requester 0 and 3 from requester 1 with concurrent reads
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      req1 = (k < 6); #1;
      chk($sformatf("t6_gnt0_%0d", k), 64'(gnt0), 64'((k >= 6) || (k % 2 == 0)));
      chk($sformatf("t6_gnt1_%0d", k), 64'(gnt1), 64'((k < 6) && (k % 2 == 1)));
    end
    @(negedge clk); req0 = 1'b0; req1 = 1'b0; #1;
`ifdef SFIFO_ARB_STAT_EN
    chk("t6_acc0", 64'(acc0_cnt), 64'd5);
    chk("t6_acc1", 64'(acc1_cnt), 64'd3);
`else
    chk("t6_acc0", 64'(acc0_cnt), 64'd0);
    chk("t6_acc1", 64'(acc1_cnt), 64'd0);
`endif
    chk("t6_level", 64'(level), 64'd1);
    @(negedge clk); rready = 1'b0; #1;
    chk("t6_empty", 64'(empty), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
